simple_counter_4bit: RTL and testbench



---
 rtl/simple_counter_4bit.sv | 64 ++++++
 tb/tb_simple_counter_4bit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/simple_counter_4bit.sv
// simple_counter_4bit
// Free-running binary counter with a programmable terminal value, a count
// direction, a combinational terminal-count flag, a registered one-cycle
// wrap pulse and a saturating 8-bit count of wraps since reset.
// Reset is synchronous and active-low. The counter has no enable, so it
// advances on every rising clock edge while reset is high.

module simple_counter_4bit #(
    parameter int WIDTH     = 4,
    parameter int MAX_VAL   = (1 << WIDTH) - 1,
    parameter int RESET_VAL = 0,
    parameter int DIRECTION = 0
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic [7:0]       wrap_count
);

    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RESET_Q = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ZERO_Q  = '0;
    localparam logic [WIDTH-1:0] ONE_Q   = WIDTH'(1);
    localparam logic             COUNT_DOWN = (DIRECTION != 0);

    logic             at_terminal;
    logic [WIDTH-1:0] next_q;

    // The terminal value is the one from which the next edge wraps:
    // MAX_VAL when counting up, zero when counting down. The wrap is
    // handled by comparison, so q never leaves the range 0..MAX_VAL.
    always_comb begin
        at_terminal = 1'b0;
        next_q      = q;
        if (COUNT_DOWN) begin
            at_terminal = (q == ZERO_Q);
            next_q      = at_terminal ? MAX_Q : (q - ONE_Q);
        end else begin
            at_terminal = (q == MAX_Q);
            next_q      = at_terminal ? ZERO_Q : (q + ONE_Q);
        end
    end

    assign tc = at_terminal;

    // Count register, wrap pulse and saturating wrap counter. Reset wins
    // over counting and never produces a wrap pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q          <= RESET_Q;
            wrap       <= 1'b0;
            wrap_count <= 8'd0;
        end else begin
            q    <= next_q;
            wrap <= at_terminal;
            if (at_terminal && (wrap_count != 8'hFF)) begin
                wrap_count <= wrap_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_simple_counter_4bit.sv
// Testbench for simple_counter_4bit.
// A table of {reset, expected outputs} records drives the default up
// counter; hand-written sequences cover free run, a custom terminal value,
// down counting with saturation of the wrap counter, and reset to MAX_VAL.

module tb_simple_counter_4bit;

    typedef struct {
        logic       rst;
        logic [3:0] q;
        logic       tc;
        logic       wrap;
        logic [7:0] wc;
    } vec_t;

    logic clk;
    logic rst_a, rst_b, rst_c, rst_d;

    logic [3:0] q_a, q_b, q_c, q_d;
    logic       tc_a, tc_b, tc_c, tc_d;
    logic       wrap_a, wrap_b, wrap_c, wrap_d;
    logic [7:0] wc_a, wc_b, wc_c, wc_d;

    int num_checks = 0;
    int num_fails  = 0;

    vec_t vecs[$];

    // Default configuration: 4-bit up counter 0..15.
    simple_counter_4bit dut_a (
        .clk(clk), .reset(rst_a), .q(q_a), .tc(tc_a),
        .wrap(wrap_a), .wrap_count(wc_a)
    );

    // Custom range 0..9.
    simple_counter_4bit #(.MAX_VAL(9)) dut_b (
        .clk(clk), .reset(rst_b), .q(q_b), .tc(tc_b),
        .wrap(wrap_b), .wrap_count(wc_b)
    );

    // Down counter.
    simple_counter_4bit #(.DIRECTION(1)) dut_c (
        .clk(clk), .reset(rst_c), .q(q_c), .tc(tc_c),
        .wrap(wrap_c), .wrap_count(wc_c)
    );

    // Up counter that resets to its terminal value.
    simple_counter_4bit #(.RESET_VAL(15)) dut_d (
        .clk(clk), .reset(rst_d), .q(q_d), .tc(tc_d),
        .wrap(wrap_d), .wrap_count(wc_d)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic r);
        rst_a = r;
        tick(1);
    endtask

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;
        rst_d = 1'b0;

        // Reset, 15 counting edges, wrap, then a mid-count reset at q = 7.
        vecs.push_back('{1'b0, 4'd0, 1'b0, 1'b0, 8'd0});
        for (int i = 1; i <= 15; i++) begin
            vecs.push_back('{1'b1, 4'(i), (i == 15), 1'b0, 8'd0});
        end
        vecs.push_back('{1'b1, 4'd0, 1'b0, 1'b1, 8'd1});
        vecs.push_back('{1'b1, 4'd1, 1'b0, 1'b0, 8'd1});
        for (int i = 2; i <= 7; i++) begin
            vecs.push_back('{1'b1, 4'(i), 1'b0, 1'b0, 8'd1});
        end
        vecs.push_back('{1'b0, 4'd0, 1'b0, 1'b0, 8'd0});
        vecs.push_back('{1'b1, 4'd1, 1'b0, 1'b0, 8'd0});
        vecs.push_back('{1'b1, 4'd2, 1'b0, 1'b0, 8'd0});

        #2;
        for (int k = 0; k < vecs.size(); k++) begin
            applyStimulus(vecs[k].rst);
            checkOutput($sformatf("vec%0d q", k),    q_a,    vecs[k].q);
            checkOutput($sformatf("vec%0d tc", k),   tc_a,   vecs[k].tc);
            checkOutput($sformatf("vec%0d wrap", k), wrap_a, vecs[k].wrap);
            checkOutput($sformatf("vec%0d wc", k),   wc_a,   vecs[k].wc);
        end

        // Two full periods after reset give two wraps.
        applyStimulus(1'b0);
        rst_a = 1'b1;
        tick(32);
        checkOutput("two_periods q", q_a, 0);
        checkOutput("two_periods wc", wc_a, 2);

        // Free run: 10 edges then 6 more.
        applyStimulus(1'b0);
        rst_a = 1'b1;
        tick(10);
        checkOutput("free_run q10", q_a, 10);
        tick(6);
        checkOutput("free_run q0", q_a, 0);
        checkOutput("free_run wc", wc_a, 1);
        checkOutput("free_run wrap", wrap_a, 1);

        // Custom range 0..9: tc only at 9, wrap back to 0.
        tick(1);
        checkOutput("range reset q", q_b, 0);
        checkOutput("range reset tc", tc_b, 0);
        rst_b = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            checkOutput($sformatf("range step%0d q", i), q_b, i % 10);
            checkOutput($sformatf("range step%0d tc", i), tc_b, (i == 9) ? 1 : 0);
            checkOutput($sformatf("range step%0d wrap", i), wrap_b, (i == 10) ? 1 : 0);
        end
        checkOutput("range wc", wc_b, 1);

        // Down counter: reset to 0, wrap to 15, then saturate wrap_count.
        checkOutput("down reset q", q_c, 0);
        checkOutput("down reset tc", tc_c, 1);
        checkOutput("down reset wc", wc_c, 0);
        rst_c = 1'b1;
        tick(1);
        checkOutput("down first q", q_c, 15);
        checkOutput("down first wrap", wrap_c, 1);
        checkOutput("down first wc", wc_c, 1);
        tick(1);
        checkOutput("down second q", q_c, 14);
        checkOutput("down second wrap", wrap_c, 0);
        tick(253 * 16 - 1);
        checkOutput("down pre_sat wc", wc_c, 254);
        tick(16);
        checkOutput("down sat wc", wc_c, 255);
        tick(48);
        checkOutput("down held wc", wc_c, 255);
        checkOutput("down held q", q_c, 15);
        checkOutput("down held wrap", wrap_c, 1);

        // Reset value at the terminal: first edge after release wraps.
        checkOutput("rstmax reset q", q_d, 15);
        checkOutput("rstmax reset tc", tc_d, 1);
        checkOutput("rstmax reset wrap", wrap_d, 0);
        rst_d = 1'b1;
        tick(1);
        checkOutput("rstmax first q", q_d, 0);
        checkOutput("rstmax first wrap", wrap_d, 1);
        checkOutput("rstmax first wc", wc_d, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
